alu_exec_unit: RTL and testbench
================================

Name: alu_exec_unit

Overview:
- Execute-stage ALU that consumes the 5-bit operation code produced by the ALU control decoder, together with two operands from the register file / immediate mux.
- Single-cycle ops (add, sub, and, or, slt, branch compares) complete in one cycle. Shifts run iteratively, one bit per cycle, so no barrel shifter is needed.
- Results are registered and delivered over a valid/ready handshake to the writeback / PC-select logic.
- Not pipelined: holds at most one operation.

Parameters:
- XLEN, 32, operand/result width.
- SHAMT_W, 5, shift-amount width; equals log2(XLEN).

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  asynchronous active-low reset.
- flush  input  1  synchronous abort; returns the block to IDLE.
- in_valid  input  1  operation request.
- in_ready  output  1  block can accept; high only in IDLE.
- alu_op  input  5  operation; encodings are the `EXE_*_OP macros in src/defines.v.
- op_a  input  XLEN  operand A (rs1).
- op_b  input  XLEN  operand B (rs2/imm); shift amount = op_b[SHAMT_W-1:0].
- out_valid  output  1  result available.
- out_ready  input  1  consumer accepts result.
- result  output  XLEN  registered result.
- zero  output  1  result == 0.
- branch_taken  output  1  compare outcome for branch ops; 0 otherwise.
- illegal_op  output  1  alu_op not in the supported set.

Behaviour:
- Reset (rst low, asynchronous):
  - state=IDLE.
  - result=0, zero=1, branch_taken=0, illegal_op=0, out_valid=0.
  - in_ready=1 once rst is released.
- States: IDLE, SHIFT, DONE.
- in_ready = (state==IDLE).
- Accept occurs at a rising edge with in_valid && in_ready. op/a/b are captured; the inputs are don't-care afterwards.
- IDLE, accept of a non-shift op: compute and register result/flags; go to DONE. out_valid rises the cycle after accept (latency 1).
  - ADD: a+b mod 2^XLEN.
  - SUB: a-b mod 2^XLEN.
  - AND, OR: bitwise.
  - SLT: signed a<b gives 1, else 0, zero-extended.
  - BEQ/BNE/BLT/BGE/BLTU/BGEU: result=a-b; branch_taken = the comparison (signed for BLT/BGE, unsigned for the U forms).
  - Unsupported op: result=0, illegal_op=1, branch_taken=0; go to DONE with no hang.
- IDLE, accept of SLL/SRL: load shift register with a and counter with shamt.
  - shamt==0: go to DONE with result=a (latency 1).
  - shamt>0: go to SHIFT.
- SHIFT: each cycle shift one bit (SLL left, SRL logical right with zero fill) and decrement the counter. When the counter transitions 1 to 0, register result and go to DONE.
  - Total latency from accept to out_valid = shamt+1 cycles; shamt=31 gives 32 cycles.
- DONE: out_valid=1. result/zero/branch_taken/illegal_op are held stable while out_ready=0.
  - On out_valid && out_ready: go to IDLE. out_valid drops and in_ready rises the next cycle. There is no same-cycle accept on completion (one dead cycle).
- zero is always (result==0) on the registered result.
- flush (highest synchronous priority): from any state, next state is IDLE and out_valid=0. result/flags keep their last values. A simultaneous in_valid is not accepted.
- rst asserted mid-SHIFT or mid-DONE: immediate return to reset values; the partial result is discarded.
- Only the accepted op is used. alu_op changing during SHIFT/DONE has no effect.
- Outputs change only on clock edges or reset; no combinational path from inputs to result.

Test Plan:
- Reset then ADD, a=0x7FFFFFFF, b=1 -> out_valid 1 cycle after accept, result=0x80000000, zero=0; SUB a=5, b=5 -> result=0, zero=1.
- SLL, a=0x1, b=31 -> out_valid exactly 32 cycles after accept, result=0x80000000, in_ready low throughout. SRL, a=0x80000000, b=0 -> result=0x80000000 at latency 1.
- Branches with a=0xFFFFFFFF, b=1:
  - BLT -> branch_taken=1.
  - BLTU -> 0.
  - BGE -> 0.
  - BGEU -> 1.
  - BEQ with a=b=7 -> branch_taken=1, zero=1.
- Backpressure: complete SLT (a=-3, b=2) with out_ready low for 5 cycles -> result=1 held stable, out_valid held, in_ready=0. out_ready high -> in_ready=1 on the following cycle.
- flush asserted 4 cycles into SLL with shamt=20 -> IDLE next cycle, out_valid never asserted. A new ADD 2+3 is then accepted and yields 5.
- Illegal alu_op=5'h1F -> illegal_op=1, result=0 at latency 1. Also: rst pulsed low mid-shift -> all outputs return to reset values asynchronously.

Source files
------------

// File: rtl/alu_exec_unit.sv
// Execute-stage ALU: single-cycle arithmetic/logic/branch compares plus
// bit-serial shifts. Ports: clk, rst (async active-low), flush, in_valid/
// in_ready + alu_op/op_a/op_b request side, out_valid/out_ready + result/
// zero/branch_taken/illegal_op response side.
`timescale 1ns/1ps

package alu_pkg;
    localparam logic [4:0] EXE_ADD_OP  = 5'h00;
    localparam logic [4:0] EXE_SUB_OP  = 5'h01;
    localparam logic [4:0] EXE_AND_OP  = 5'h02;
    localparam logic [4:0] EXE_OR_OP   = 5'h03;
    localparam logic [4:0] EXE_SLT_OP  = 5'h04;
    localparam logic [4:0] EXE_SLL_OP  = 5'h05;
    localparam logic [4:0] EXE_SRL_OP  = 5'h06;
    localparam logic [4:0] EXE_BEQ_OP  = 5'h08;
    localparam logic [4:0] EXE_BNE_OP  = 5'h09;
    localparam logic [4:0] EXE_BLT_OP  = 5'h0A;
    localparam logic [4:0] EXE_BGE_OP  = 5'h0B;
    localparam logic [4:0] EXE_BLTU_OP = 5'h0C;
    localparam logic [4:0] EXE_BGEU_OP = 5'h0D;
endpackage

module alu_exec_unit
    import alu_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int SHAMT_W = 5
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [4:0]      alu_op,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            zero,
    output logic            branch_taken,
    output logic            illegal_op
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SHIFT,
        S_DONE
    } state_e;

    state_e              state_q, state_d;
    logic [XLEN-1:0]     res_q, res_d;
    logic [XLEN-1:0]     sh_q, sh_d;
    logic [SHAMT_W-1:0]  cnt_q, cnt_d;
    logic                left_q, left_d;
    logic                br_q, br_d;
    logic                ill_q, ill_d;

    logic [XLEN-1:0]     diff;
    logic [XLEN-1:0]     sh_nxt;
    logic [SHAMT_W-1:0]  shamt;
    logic                lt_s;
    logic                lt_u;

    assign diff   = op_a - op_b;
    assign lt_s   = $signed(op_a) < $signed(op_b);
    assign lt_u   = op_a < op_b;
    assign shamt  = op_b[SHAMT_W-1:0];
    assign sh_nxt = left_q ? {sh_q[XLEN-2:0], 1'b0}
                           : {1'b0, sh_q[XLEN-1:1]};

    always_comb begin
        state_d = state_q;
        res_d   = res_q;
        sh_d    = sh_q;
        cnt_d   = cnt_q;
        left_d  = left_q;
        br_d    = br_q;
        ill_d   = ill_q;
        if (flush) begin
            // Abort wins over everything; result/flags are left as they were.
            state_d = S_IDLE;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (in_valid) begin
                        br_d    = 1'b0;
                        ill_d   = 1'b0;
                        state_d = S_DONE;
                        case (alu_op)
                            EXE_ADD_OP:  res_d = op_a + op_b;
                            EXE_SUB_OP:  res_d = diff;
                            EXE_AND_OP:  res_d = op_a & op_b;
                            EXE_OR_OP:   res_d = op_a | op_b;
                            EXE_SLT_OP:  res_d = {{(XLEN-1){1'b0}}, lt_s};
                            EXE_BEQ_OP:  begin res_d = diff; br_d = (op_a == op_b); end
                            EXE_BNE_OP:  begin res_d = diff; br_d = (op_a != op_b); end
                            EXE_BLT_OP:  begin res_d = diff; br_d = lt_s;  end
                            EXE_BGE_OP:  begin res_d = diff; br_d = ~lt_s; end
                            EXE_BLTU_OP: begin res_d = diff; br_d = lt_u;  end
                            EXE_BGEU_OP: begin res_d = diff; br_d = ~lt_u; end
                            EXE_SLL_OP, EXE_SRL_OP: begin
                                sh_d   = op_a;
                                cnt_d  = shamt;
                                left_d = (alu_op == EXE_SLL_OP);
                                if (shamt == '0) begin
                                    res_d = op_a;
                                end else begin
                                    state_d = S_SHIFT;
                                end
                            end
                            default: begin
                                res_d = '0;
                                ill_d = 1'b1;
                            end
                        endcase
                    end
                end
                S_SHIFT: begin
                    sh_d  = sh_nxt;
                    cnt_d = cnt_q - {{(SHAMT_W-1){1'b0}}, 1'b1};
                    if (cnt_q == {{(SHAMT_W-1){1'b0}}, 1'b1}) begin
                        res_d   = sh_nxt;
                        state_d = S_DONE;
                    end
                end
                S_DONE: begin
                    if (out_ready) state_d = S_IDLE;
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            res_q   <= '0;
            sh_q    <= '0;
            cnt_q   <= '0;
            left_q  <= 1'b0;
            br_q    <= 1'b0;
            ill_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            res_q   <= res_d;
            sh_q    <= sh_d;
            cnt_q   <= cnt_d;
            left_q  <= left_d;
            br_q    <= br_d;
            ill_q   <= ill_d;
        end
    end

    assign in_ready     = (state_q == S_IDLE);
    assign out_valid    = (state_q == S_DONE);
    assign result       = res_q;
    assign zero         = (res_q == '0);
    assign branch_taken = br_q;
    assign illegal_op   = ill_q;

endmodule

// File: tb/tb_alu_exec_unit.sv
// Scoreboard bench for alu_exec_unit.
// Expected results are queued at issue and compared on out_valid.
`timescale 1ns/1ps

module tb_alu_exec_unit;
    import alu_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [4:0]  alu_op = '0;
    logic [31:0] op_a = '0;
    logic [31:0] op_b = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] result;
    logic        zero;
    logic        branch_taken;
    logic        illegal_op;

    typedef struct {
        logic [31:0] res;
        logic        zero;
        logic        br;
        logic        ill;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    alu_exec_unit dut (
        .clk          (clk),
        .rst          (rst),
        .flush        (flush),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .alu_op       (alu_op),
        .op_a         (op_a),
        .op_b         (op_b),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .result       (result),
        .zero         (zero),
        .branch_taken (branch_taken),
        .illegal_op   (illegal_op)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic exp_t model(input logic [4:0] op,
                                   input logic [31:0] a,
                                   input logic [31:0] b);
        exp_t e;
        int signed sa, sb_;
        sa = a;
        sb_ = b;
        e.br  = 1'b0;
        e.ill = 1'b0;
        e.res = a - b;
        case (op)
            EXE_ADD_OP:  e.res = a + b;
            EXE_SUB_OP:  e.res = a - b;
            EXE_AND_OP:  e.res = a & b;
            EXE_OR_OP:   e.res = a | b;
            EXE_SLT_OP:  e.res = (sa < sb_) ? 32'd1 : 32'd0;
            EXE_SLL_OP:  e.res = a << b[4:0];
            EXE_SRL_OP:  e.res = a >> b[4:0];
            EXE_BEQ_OP:  e.br = (a == b);
            EXE_BNE_OP:  e.br = (a != b);
            EXE_BLT_OP:  e.br = (sa < sb_);
            EXE_BGE_OP:  e.br = (sa >= sb_);
            EXE_BLTU_OP: e.br = (a < b);
            EXE_BGEU_OP: e.br = (a >= b);
            default: begin
                e.res = 32'd0;
                e.ill = 1'b1;
            end
        endcase
        e.zero = (e.res == 32'd0);
        return e;
    endfunction

    task automatic run_op(input string tag, input logic [4:0] op,
                          input logic [31:0] a, input logic [31:0] b,
                          input int hold, input int exp_lat);
        exp_t e;
        int lat;
        int rdy_hi;
        sb.push_back(model(op, a, b));
        @(negedge clk);
        alu_op   = op;
        op_a     = a;
        op_b     = b;
        in_valid = 1'b1;
        check({tag, "_in_ready_idle"}, in_ready, 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        alu_op   = 5'($urandom);
        op_a     = $urandom;
        op_b     = $urandom;
        lat      = 1;
        rdy_hi   = 0;
        while (!out_valid && lat < 200) begin
            if (in_ready) rdy_hi++;
            @(posedge clk);
            #1;
            lat++;
        end
        check({tag, "_out_valid"}, out_valid, 1);
        check({tag, "_busy_in_ready"}, rdy_hi + in_ready, 0);
        if (exp_lat > 0) check({tag, "_latency"}, lat, exp_lat);
        e = sb.pop_front();
        check({tag, "_result"}, result, e.res);
        check({tag, "_zero"}, zero, e.zero);
        check({tag, "_branch"}, branch_taken, e.br);
        check({tag, "_illegal"}, illegal_op, e.ill);
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            #1;
            check({tag, "_hold_result"}, result, e.res);
            check({tag, "_hold_valid"}, out_valid, 1);
            check({tag, "_hold_in_ready"}, in_ready, 0);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check({tag, "_post_valid"}, out_valid, 0);
        check({tag, "_post_in_ready"}, in_ready, 1);
    endtask

    initial begin
        int seen;
        #12;
        check("rst_result", result, 0);
        check("rst_zero", zero, 1);
        check("rst_branch", branch_taken, 0);
        check("rst_illegal", illegal_op, 0);
        check("rst_out_valid", out_valid, 0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("rst_in_ready", in_ready, 1);

        run_op("add_ovf", EXE_ADD_OP, 32'h7FFF_FFFF, 32'd1, 0, 1);
        run_op("sub_zero", EXE_SUB_OP, 32'd5, 32'd5, 0, 1);
        run_op("and", EXE_AND_OP, 32'hF0F0_1234, 32'h0FF0_FF00, 0, 1);
        run_op("or", EXE_OR_OP, 32'hF000_0001, 32'h0000_1000, 0, 1);
        run_op("sll31", EXE_SLL_OP, 32'h1, 32'd31, 0, 32);
        run_op("srl0", EXE_SRL_OP, 32'h8000_0000, 32'd0, 0, 1);
        run_op("srl7", EXE_SRL_OP, 32'h8000_00F0, 32'hFFFF_FFE7, 0, 8);
        run_op("blt", EXE_BLT_OP, 32'hFFFF_FFFF, 32'd1, 0, 1);
        run_op("bltu", EXE_BLTU_OP, 32'hFFFF_FFFF, 32'd1, 0, 1);
        run_op("bge", EXE_BGE_OP, 32'hFFFF_FFFF, 32'd1, 0, 1);
        run_op("bgeu", EXE_BGEU_OP, 32'hFFFF_FFFF, 32'd1, 0, 1);
        run_op("beq", EXE_BEQ_OP, 32'd7, 32'd7, 0, 1);
        run_op("bne", EXE_BNE_OP, 32'd7, 32'd7, 0, 1);
        run_op("slt_bp", EXE_SLT_OP, 32'hFFFF_FFFD, 32'd2, 5, 1);

        // flush 4 cycles into a long shift
        @(negedge clk);
        alu_op   = EXE_SLL_OP;
        op_a     = 32'h3;
        op_b     = 32'd20;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        flush    = 1'b1;
        in_valid = 1'b1;
        alu_op   = EXE_ADD_OP;
        @(posedge clk);
        #1;
        flush    = 1'b0;
        in_valid = 1'b0;
        check("flush_in_ready", in_ready, 1);
        check("flush_out_valid", out_valid, 0);
        check("flush_result_kept", result, 32'd1);
        seen = 0;
        repeat (30) begin
            @(posedge clk);
            #1;
            if (out_valid) seen++;
        end
        check("flush_no_valid", seen, 0);
        run_op("add_after_flush", EXE_ADD_OP, 32'd2, 32'd3, 0, 1);

        run_op("illegal", 5'h1F, 32'h1234_5678, 32'h9, 0, 1);

        // async reset in the middle of a shift
        @(negedge clk);
        alu_op   = EXE_SLL_OP;
        op_a     = 32'h1;
        op_b     = 32'd10;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        check("midrst_result", result, 0);
        check("midrst_zero", zero, 1);
        check("midrst_out_valid", out_valid, 0);
        check("midrst_branch", branch_taken, 0);
        check("midrst_illegal", illegal_op, 0);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("midrst_in_ready", in_ready, 1);
        seen = 0;
        repeat (15) begin
            @(posedge clk);
            #1;
            if (out_valid) seen++;
        end
        check("midrst_no_valid", seen, 0);
        run_op("sll4_after_rst", EXE_SLL_OP, 32'h0000_0009, 32'd4, 2, 5);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
